// File: rtl/waterfall_pkg.sv
// Shared defaults and handshake state encoding for the waterfall front end.
package waterfall_pkg;

  localparam int unsigned SAMPLE_WIDTH_DEF = 12;
  localparam int unsigned DATA_W_DEF       = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } hs_state_t;

endpackage

// File: rtl/dc_tracker.sv
// First-order IIR DC estimate: acc += x - (acc >> DC_SHIFT), dc = acc >> DC_SHIFT.
// Only instantiated when SAMPLE_COND_DC_EN is defined.
module dc_tracker #(
  parameter int unsigned SAMPLE_WIDTH = 12,
  parameter int unsigned DC_SHIFT     = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [SAMPLE_WIDTH-1:0] in_data,
  output logic [SAMPLE_WIDTH-1:0] dc
);

  localparam int unsigned ACC_W = SAMPLE_WIDTH + DC_SHIFT;

  logic [ACC_W-1:0]        r_acc;
  logic [SAMPLE_WIDTH-1:0] w_dc;

  assign w_dc = SAMPLE_WIDTH'(r_acc >> DC_SHIFT);
  assign dc   = w_dc;

  // Accumulator starts at mid-scale so the estimate begins at 2^(SAMPLE_WIDTH-1)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= ACC_W'(1) << (ACC_W - 1);
    end else if (in_valid) begin
      r_acc <= r_acc + ACC_W'(in_data) - ACC_W'(w_dc);
    end
  end

endmodule

// File: rtl/sample_conditioner.sv
// ADC decimator, DC removal, gain/saturation and start/ready handshake toward
// the sliding DFT. Define SAMPLE_COND_DC_EN to track DC with an IIR instead
// of the fixed mid-scale offset.
module sample_conditioner
  import waterfall_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned DECIM        = 4,
  parameter int unsigned DC_SHIFT     = 6,
  parameter int unsigned GAIN_SHIFT   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] adc_data,
  input  logic                    adc_valid,
  input  logic                    fft_ready,
  output logic                    fft_start,
  output logic [DATA_W-1:0]       fft_sample,
  output logic                    overflow,
  output logic [7:0]              drop_count,
  output logic [DATA_W-2:0]       level
);

  localparam int unsigned LOG_DECIM = $clog2(DECIM);
  localparam int unsigned CNT_W     = (LOG_DECIM > 0) ? LOG_DECIM : 1;
  localparam int unsigned SUM_W     = SAMPLE_WIDTH + LOG_DECIM;
  localparam int unsigned C_W       = SAMPLE_WIDTH + 1;
  localparam int unsigned SHIFT     = SAMPLE_WIDTH - DATA_W - GAIN_SHIFT;
  localparam int unsigned LVL_W     = DATA_W - 1;

  localparam logic signed [C_W-1:0] SAT_MAX = C_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [C_W-1:0] SAT_MIN = ~SAT_MAX;

  logic [SUM_W-1:0]        r_acc;
  logic [SUM_W-1:0]        w_sum;
  logic [CNT_W-1:0]        r_cnt;
  logic [SAMPLE_WIDTH-1:0] r_avg;
  logic                    r_avg_valid;
  logic [SAMPLE_WIDTH-1:0] w_dc;

  logic signed [C_W-1:0]   w_centred;
  logic signed [C_W-1:0]   w_shifted;
  logic [DATA_W-1:0]       w_scaled;
  logic                    w_clip;
  logic [DATA_W-1:0]       w_neg;
  logic [LVL_W-1:0]        w_mag;
  logic [LVL_W-1:0]        w_lvl_dec;
  logic [LVL_W-1:0]        w_lvl_next;
  logic                    w_take;

  hs_state_t               r_state;
  logic [DATA_W-1:0]       r_pend;
  logic                    r_pend_valid;
  logic                    r_start;
  logic [DATA_W-1:0]       r_sample;
  logic                    r_ovf;
  logic [7:0]              r_drop;
  logic [LVL_W-1:0]        r_level;

`ifdef SAMPLE_COND_DC_EN
  dc_tracker #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .DC_SHIFT     (DC_SHIFT)
  ) u_dc_tracker (
    .clk      (clk),
    .reset    (reset),
    .in_valid (r_avg_valid),
    .in_data  (r_avg),
    .dc       (w_dc)
  );
`else
  assign w_dc = SAMPLE_WIDTH'(1) << (SAMPLE_WIDTH - 1);
`endif

  assign w_sum = r_acc + SUM_W'(adc_data);

  // Boxcar decimator: the DECIMth sample is folded in directly so none is lost
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_avg       <= '0;
      r_avg_valid <= 1'b0;
    end else begin
      r_avg_valid <= 1'b0;
      if (adc_valid) begin
        if (r_cnt == CNT_W'(DECIM - 1)) begin
          r_avg       <= SAMPLE_WIDTH'(w_sum >> LOG_DECIM);
          r_acc       <= '0;
          r_cnt       <= '0;
          r_avg_valid <= 1'b1;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign w_centred = $signed({1'b0, r_avg}) - $signed({1'b0, w_dc});
  assign w_shifted = w_centred >>> SHIFT;
  assign w_take    = (r_state == S_IDLE) && r_pend_valid && fft_ready;

  // Saturate to DATA_W and derive the clipped magnitude for the peak meter
  always_comb begin
    w_scaled = w_shifted[DATA_W-1:0];
    w_clip   = 1'b0;
    if (w_shifted > SAT_MAX) begin
      w_scaled = SAT_MAX[DATA_W-1:0];
      w_clip   = 1'b1;
    end else if (w_shifted < SAT_MIN) begin
      w_scaled = SAT_MIN[DATA_W-1:0];
      w_clip   = 1'b1;
    end
    w_neg = ~w_scaled + DATA_W'(1);
    if (!w_scaled[DATA_W-1]) begin
      w_mag = w_scaled[LVL_W-1:0];
    end else if (w_neg[DATA_W-1]) begin
      w_mag = '1;
    end else begin
      w_mag = w_neg[LVL_W-1:0];
    end
    w_lvl_dec  = (r_level == '0) ? '0 : r_level - LVL_W'(1);
    w_lvl_next = (w_mag > w_lvl_dec) ? w_mag : w_lvl_dec;
  end

  // Pending slot, status flags and the start/ready handshake FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_start      <= 1'b0;
      r_sample     <= '0;
      r_ovf        <= 1'b0;
      r_drop       <= '0;
      r_level      <= '0;
    end else begin
      if (r_avg_valid) begin
        r_pend       <= w_scaled;
        r_pend_valid <= 1'b1;
        r_level      <= w_lvl_next;
        if (w_clip) begin
          r_ovf <= 1'b1;
        end
        if (r_pend_valid && !w_take && (r_drop != 8'hFF)) begin
          r_drop <= r_drop + 8'd1;
        end
      end else if (w_take) begin
        r_pend_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_state  <= S_START;
            r_start  <= 1'b1;
            r_sample <= r_pend;
          end
        end
        S_START: begin
          if (!fft_ready) begin
            r_state <= S_WAIT;
            r_start <= 1'b0;
          end
        end
        S_WAIT: begin
          if (fft_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_start <= 1'b0;
        end
      endcase
    end
  end

  assign fft_start  = r_start;
  assign fft_sample = r_sample;
  assign overflow   = r_ovf;
  assign drop_count = r_drop;
  assign level      = r_level;

endmodule

// File: tb/tb_sample_conditioner.sv
// Scoreboard bench for sample_conditioner (default parameters).
module tb_sample_conditioner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic        fft_ready;
  logic        fft_start;
  logic [7:0]  fft_sample;
  logic        overflow;
  logic [7:0]  drop_count;
  logic [6:0]  level;

  logic        model_en = 1'b0;
  logic        model_ready = 1'b1;
  logic        manual_ready = 1'b1;

  int          vectors = 0;
  int          miscompares = 0;
  int          exp_q[$];
  logic        decay_mode = 1'b0;
  int          prev_out = 0;
  int          decay_n = 0;
  int          first_zero = -1;

  assign fft_ready = model_en ? model_ready : manual_ready;

  always #5 clk = ~clk;

  sample_conditioner dut (
    .clk        (clk),
    .reset      (reset),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .fft_ready  (fft_ready),
    .fft_start  (fft_start),
    .fft_sample (fft_sample),
    .overflow   (overflow),
    .drop_count (drop_count),
    .level      (level)
  );

  // DFT stand-in: acknowledge each start by dropping ready for one cycle
  always @(negedge clk) begin
    if (fft_start && model_ready) model_ready = 1'b0;
    else                          model_ready = 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int v);
    adc_data  = 12'(v);
    adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
  endtask

  task automatic group(input int v, input int gap);
    repeat (4) begin
      send(v);
      tick(gap - 1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Pops an expectation on every rising fft_start, or checks decay shape
  task automatic monitor();
    logic prev_start;
    int   cur;
    int   e;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (fft_start && !prev_start) begin
        cur = int'($signed(fft_sample));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("fft_sample", cur, e);
        end else if (decay_mode) begin
          vectors++;
          if (cur > prev_out || cur < 0) begin
            miscompares++;
            $display("FAIL decay_monotonic: got %0d after %0d, required 0..%0d", cur, prev_out, prev_out);
          end
          decay_n++;
          if (cur == 0 && first_zero < 0) first_zero = decay_n;
        end else begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_start: got sample %0d, required no output", cur);
        end
        prev_out = cur;
      end
      prev_start = fft_start;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none

    @(negedge clk);
    do_reset();
    chk("rst_fft_start", int'(fft_start), 0);
    chk("rst_fft_sample", int'(fft_sample), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_drop_count", int'(drop_count), 0);
    chk("rst_level", int'(level), 0);

    // Mid-scale input every 10 cycles must centre to zero
    model_en = 1'b1;
    for (int g = 0; g < 3; g++) begin
      exp_q.push_back(0);
      group(2048, 10);
    end
    wait_drain("mid_drain", 50);
    chk("mid_overflow", int'(overflow), 0);
    chk("mid_level", int'(level), 0);
    chk("mid_drop", int'(drop_count), 0);

`ifndef SAMPLE_COND_DC_EN
    // Full-scale positive and negative saturation with fixed DC
    do_reset();
    exp_q.push_back(127);
    group(4095, 2);
    wait_drain("pos_drain1", 30);
    chk("pos_overflow", int'(overflow), 1);
    for (int g = 0; g < 2; g++) begin
      exp_q.push_back(127);
      group(4095, 2);
    end
    wait_drain("pos_drain", 30);
    chk("pos_level", int'(level), 127);
    do_reset();
    for (int g = 0; g < 3; g++) begin
      exp_q.push_back(-128);
      group(0, 2);
    end
    wait_drain("neg_drain", 30);
    chk("neg_overflow", int'(overflow), 1);
    chk("neg_level", int'(level), 127);
`else
    // Settled at mid-scale, then a +512 step decays as DC catches up
    do_reset();
    for (int g = 0; g < 3; g++) begin
      exp_q.push_back(0);
      group(2048, 2);
    end
    wait_drain("settle_drain", 30);
    exp_q.push_back(64);
    decay_mode = 1'b1;
    for (int g = 0; g < 600; g++) group(2560, 2);
    tick(20);
    decay_mode = 1'b0;
    chk("decay_outputs", decay_n, 599);
    chk("decay_reached_zero", int'(first_zero > 0), 1);
    chk("decay_drop", int'(drop_count), 0);
`endif

    // Ready held low across three outputs: only the newest is sent
    do_reset();
    model_en = 1'b0;
    manual_ready = 1'b0;
    group(2048, 2);
    group(2048, 2);
    group(2128, 2);
    tick(10);
    chk("drop_count", int'(drop_count), 2);
    chk("drop_no_start", int'(fft_start), 0);
    exp_q.push_back(10);
    manual_ready = 1'b1;
    wait_drain("drop_drain", 10);
    manual_ready = 1'b0;
    tick(2);
    manual_ready = 1'b1;
    tick(3);
    chk("drop_count_after", int'(drop_count), 2);

    // Cycle-exact latency: start at N+3, ready low at N+5, start low at N+6
    do_reset();
    manual_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(2088);
      tick(1);
    end
    exp_q.push_back(5);
    send(2088);
    chk("lat_n1", int'(fft_start), 0);
    tick(1);
    chk("lat_n2", int'(fft_start), 0);
    tick(1);
    chk("lat_n3", int'(fft_start), 1);
    tick(1);
    chk("lat_n4", int'(fft_start), 1);
    tick(1);
    chk("lat_n5", int'(fft_start), 1);
    manual_ready = 1'b0;
    tick(1);
    chk("lat_n6", int'(fft_start), 0);
    manual_ready = 1'b1;
    tick(3);
    wait_drain("lat_drain", 5);

    // Reset while parked in S_START with partial accumulation in flight
    do_reset();
    manual_ready = 1'b1;
    exp_q.push_back(127);
    group(4095, 2);
    wait_drain("pre_rst_drain", 20);
    group(4095, 2);
    group(4095, 2);
    send(4095);
    tick(1);
    send(4095);
    chk("pre_rst_start", int'(fft_start), 1);
    chk("pre_rst_drop", int'(drop_count), 1);
    chk("pre_rst_overflow", int'(overflow), 1);
    reset = 1'b1;
    adc_data = 12'd4095;
    adc_valid = 1'b1;
    @(negedge clk);
    chk("abort_fft_start", int'(fft_start), 0);
    chk("abort_fft_sample", int'(fft_sample), 0);
    chk("abort_overflow", int'(overflow), 0);
    chk("abort_drop", int'(drop_count), 0);
    chk("abort_level", int'(level), 0);
    @(negedge clk);
    reset = 1'b0;
    adc_valid = 1'b0;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      send(2128);
      tick(1);
    end
    tick(10);
    chk("post_rst_no_start", int'(fft_start), 0);
    exp_q.push_back(10);
    send(2128);
    wait_drain("post_rst_drain", 10);
    chk("post_rst_overflow", int'(overflow), 0);
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
